// File: rtl/nn_mem_loader_if.sv
// Byte-stream input and memory write ports of the NN memory loader.
// master: the loader side (consumes bytes, drives the memory write ports).
// slave:  the stream source / memory side.
interface nn_mem_loader_if #(
  parameter int AW = 16
);
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          in_we;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_data;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [11:0]   w_data;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  s_data, s_valid,
    output s_ready, in_we, in_addr, in_data, w_we, w_addr, w_data, busy, done, err
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready, in_we, in_addr, in_data, w_we, w_addr, w_data, busy, done, err
  );
endinterface

// File: rtl/nn_mem_loader.sv
// NN memory loader: parses a header-tagged byte stream and writes either
// 8-bit input-vector entries or 12-bit weight entries (sent as low/high byte
// pairs) into two memories through registered write ports.
// Optional feature macro: NN_LOADER_CHKSUM_EN adds a trailing checksum byte
// (mod-256 sum of payload bytes, header excluded) checked in a CHK state.
module nn_mem_loader #(
  parameter int N_IN = 784,
  parameter int N_W  = 784,
  parameter int AW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  nn_mem_loader_if.master bus
);

`ifdef NN_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {IDLE, IN_LOAD, W_LO, W_HI, FIN, CHK} state_t;
  localparam state_t AFTER_PAYLOAD = CHK;
`else
  typedef enum logic [2:0] {IDLE, IN_LOAD, W_LO, W_HI, FIN} state_t;
  localparam state_t AFTER_PAYLOAD = FIN;
`endif

  localparam logic [AW-1:0] IN_LAST = AW'(N_IN - 1);
  localparam logic [AW-1:0] W_LAST  = AW'(N_W - 1);

  state_t state_q, state_d;

  logic [AW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [7:0]    lo_q, lo_d;
  logic          in_we_q, in_we_d;
  logic [AW-1:0] in_addr_q, in_addr_d;
  logic [7:0]    in_data_q, in_data_d;
  logic          w_we_q, w_we_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [11:0]   w_data_q, w_data_d;
  logic          done_q;
`ifdef NN_LOADER_CHKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic s_ready_c;
  logic accept;

  // FIN is the only state that refuses bytes; it gives the memories a
  // quiet cycle between the last write and the done pulse.
  assign s_ready_c = (state_q != FIN);
  assign accept    = bus.s_valid && s_ready_c;

  assign bus.s_ready = s_ready_c;
  assign bus.busy    = (state_q != IDLE);
  assign bus.in_we   = in_we_q;
  assign bus.in_addr = in_addr_q;
  assign bus.in_data = in_data_q;
  assign bus.w_we    = w_we_q;
  assign bus.w_addr  = w_addr_q;
  assign bus.w_data  = w_data_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and next-datapath decode; nothing moves unless a byte is accepted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    lo_d      = lo_q;
    in_we_d   = 1'b0;
    in_addr_d = in_addr_q;
    in_data_d = in_data_q;
    w_we_d    = 1'b0;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
`ifdef NN_LOADER_CHKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.s_data == 8'h01 || bus.s_data == 8'h02) begin
            state_d = (bus.s_data == 8'h01) ? IN_LOAD : W_LO;
            cnt_d   = '0;
            err_d   = 1'b0;
`ifdef NN_LOADER_CHKSUM_EN
            sum_d   = 8'h00;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      IN_LOAD: begin
        if (accept) begin
          in_we_d   = 1'b1;
          in_addr_d = cnt_q;
          in_data_d = bus.s_data;
          cnt_d     = cnt_q + AW'(1);
`ifdef NN_LOADER_CHKSUM_EN
          sum_d     = sum_q + bus.s_data;
`endif
          if (cnt_q == IN_LAST) state_d = AFTER_PAYLOAD;
        end
      end
      W_LO: begin
        if (accept) begin
          lo_d    = bus.s_data;
          state_d = W_HI;
`ifdef NN_LOADER_CHKSUM_EN
          sum_d   = sum_q + bus.s_data;
`endif
        end
      end
      W_HI: begin
        if (accept) begin
          // Upper nibble must be zero; flag it but still write the 12-bit value.
          if (bus.s_data[7:4] != 4'h0) err_d = 1'b1;
          w_we_d   = 1'b1;
          w_addr_d = cnt_q;
          w_data_d = {bus.s_data[3:0], lo_q};
          cnt_d    = cnt_q + AW'(1);
`ifdef NN_LOADER_CHKSUM_EN
          sum_d    = sum_q + bus.s_data;
`endif
          state_d  = (cnt_q == W_LAST) ? AFTER_PAYLOAD : W_LO;
        end
      end
`ifdef NN_LOADER_CHKSUM_EN
      CHK: begin
        if (accept) begin
          if (bus.s_data != sum_q) err_d = 1'b1;
          state_d = FIN;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered write strobes; done follows the FIN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      lo_q      <= 8'h00;
      in_we_q   <= 1'b0;
      in_addr_q <= '0;
      in_data_q <= 8'h00;
      w_we_q    <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= 12'h000;
      done_q    <= 1'b0;
`ifdef NN_LOADER_CHKSUM_EN
      sum_q     <= 8'h00;
`endif
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      lo_q      <= lo_d;
      in_we_q   <= in_we_d;
      in_addr_q <= in_addr_d;
      in_data_q <= in_data_d;
      w_we_q    <= w_we_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      done_q    <= (state_q == FIN);
`ifdef NN_LOADER_CHKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_nn_mem_loader.sv
// Directed bench for nn_mem_loader: input load, weight load, bad weight high
// byte, stalls, bad header, reset abort (and checksum when
// NN_LOADER_CHKSUM_EN is defined).
module tb_nn_mem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nn_mem_loader_if #(.AW(16)) bus ();

  nn_mem_loader #(.N_IN(784), .N_W(784), .AW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Write/done monitor, sampled on the falling edge.
  int in_a[$];
  int in_d[$];
  int w_a[$];
  int w_d[$];
  int both_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  int cyc = 0;
  logic [7:0] sum = 8'h00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.in_we === 1'b1) begin
      in_a.push_back(int'(bus.in_addr));
      in_d.push_back(int'(bus.in_data));
      last_wr_cyc = cyc;
    end
    if (bus.w_we === 1'b1) begin
      w_a.push_back(int'(bus.w_addr));
      w_d.push_back(int'(bus.w_data));
      last_wr_cyc = cyc;
    end
    if (bus.in_we === 1'b1 && bus.w_we === 1'b1) both_cnt = both_cnt + 1;
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    in_a.delete();
    in_d.delete();
    w_a.delete();
    w_d.delete();
    done_cnt = 0;
  endtask

  // Present one byte for one cycle (always accepted outside FIN).
  task automatic send(input logic [7:0] b);
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_pay(input logic [7:0] b);
    sum = sum + b;
    send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int bad;
  int k;
  logic [7:0] pat;

  initial begin
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("reset released");

    chk("rst_in_we",   32'(bus.in_we),   0);
    chk("rst_w_we",    32'(bus.w_we),    0);
    chk("rst_done",    32'(bus.done),    0);
    chk("rst_err",     32'(bus.err),     0);
    chk("rst_busy",    32'(bus.busy),    0);
    chk("rst_s_ready", 32'(bus.s_ready), 1);
    chk("rst_in_addr", 32'(bus.in_addr), 0);
    chk("rst_w_data",  32'(bus.w_data),  0);

    // Input-vector load: 0x01 then 0x00..0xFF repeating, back to back.
    clr();
    sum = 8'h00;
    send(8'h01);
    send_pay(8'h00);
    chk("a_first_we",   32'(bus.in_we),   1);
    chk("a_first_addr", 32'(bus.in_addr), 0);
    chk("a_busy",       32'(bus.busy),    1);
    for (int i = 1; i < 784; i++) begin
      pat = 8'(i);
      send_pay(pat);
    end
`ifndef NN_LOADER_CHKSUM_EN
    chk("a_fin_ready", 32'(bus.s_ready), 0);
    chk("a_fin_busy",  32'(bus.busy),    1);
`else
    send(sum);
`endif
    idle(4);
    bad = 0;
    for (int i = 0; i < in_a.size(); i++)
      if (in_a[i] != i || in_d[i] != (i % 256)) bad++;
    chk("a_in_count", 32'(in_a.size()), 784);
    chk("a_in_bad",   32'(bad),         0);
    chk("a_w_count",  32'(w_a.size()),  0);
    chk("a_done_cnt", 32'(done_cnt),    1);
`ifndef NN_LOADER_CHKSUM_EN
    chk("a_done_lat", 32'(done_cyc - last_wr_cyc), 1);
`endif
    chk("a_busy_end", 32'(bus.busy),    0);
    chk("a_err",      32'(bus.err),     0);
    $display("input load: %0d writes, %0d done", in_a.size(), done_cnt);

    // Weight load: 0x02 then (0x34,0x0A) x784.
    clr();
    sum = 8'h00;
    send(8'h02);
    for (int i = 0; i < 784; i++) begin
      send_pay(8'h34);
      send_pay(8'h0A);
    end
`ifdef NN_LOADER_CHKSUM_EN
    send(sum);
`endif
    idle(4);
    bad = 0;
    for (int i = 0; i < w_a.size(); i++)
      if (w_a[i] != i || w_d[i] != 32'hA34) bad++;
    chk("b_w_count",  32'(w_a.size()), 784);
    chk("b_w_bad",    32'(bad),        0);
    chk("b_in_count", 32'(in_a.size()), 0);
    chk("b_err",      32'(bus.err),    0);
    chk("b_done_cnt", 32'(done_cnt),   1);
    $display("weight load: %0d writes, %0d done", w_a.size(), done_cnt);

    // Weight load whose first high byte has a non-zero upper nibble.
    clr();
    sum = 8'h00;
    send(8'h02);
    send_pay(8'h11);
    send_pay(8'h5A);
    chk("c_w_we",   32'(bus.w_we),   1);
    chk("c_w_data", 32'(bus.w_data), 32'hA11);
    chk("c_err",    32'(bus.err),    1);
    for (int i = 1; i < 784; i++) begin
      send_pay(8'h34);
      send_pay(8'h0A);
    end
`ifdef NN_LOADER_CHKSUM_EN
    send(sum);
`endif
    idle(4);
    chk("c_err_held", 32'(bus.err),    1);
    chk("c_done_cnt", 32'(done_cnt),   1);
    chk("c_w_count",  32'(w_a.size()), 784);
    $display("bad high byte load: err=%0b", bus.err);

    // Next 0x01 header clears err; this load stalls one cycle between bytes.
    clr();
    sum = 8'h00;
    send(8'h01);
    chk("d_err_clr", 32'(bus.err), 0);
    for (int i = 0; i < 784; i++) begin
      pat = 8'(i * 7);
      send_pay(pat);
      bus.s_data = 8'hEE;
      idle(1);
    end
`ifdef NN_LOADER_CHKSUM_EN
    send(sum);
`endif
    idle(4);
    bad = 0;
    for (int i = 0; i < in_a.size(); i++)
      if (in_a[i] != i || in_d[i] != ((i * 7) % 256)) bad++;
    chk("d_in_count", 32'(in_a.size()), 784);
    chk("d_in_bad",   32'(bad),         0);
    chk("d_done_cnt", 32'(done_cnt),    1);
    chk("d_both_we",  32'(both_cnt),    0);
    $display("stalled input load: %0d writes", in_a.size());

    // Bad header.
    clr();
    send(8'h07);
    idle(2);
    chk("e_err",      32'(bus.err),     1);
    chk("e_busy",     32'(bus.busy),    0);
    chk("e_s_ready",  32'(bus.s_ready), 1);
    chk("e_writes",   32'(in_a.size() + w_a.size()), 0);
    $display("bad header: err=%0b", bus.err);

    // Reset after 100 input bytes; the byte in the reset cycle is dropped.
    clr();
    send(8'h01);
    for (int i = 0; i < 100; i++) send(8'hC3);
    bus.s_data  = 8'h99;
    bus.s_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    idle(5);
    chk("f_in_count", 32'(in_a.size()), 100);
    chk("f_done_cnt", 32'(done_cnt),    0);
    chk("f_busy",     32'(bus.busy),    0);
    chk("f_in_addr",  32'(bus.in_addr), 0);
    send(8'h01);
    send(8'h55);
    chk("f_restart_we",   32'(bus.in_we),   1);
    chk("f_restart_addr", 32'(bus.in_addr), 0);
    chk("f_restart_data", 32'(bus.in_data), 32'h55);
    $display("reset abort: %0d writes before reset", 100);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

`ifdef NN_LOADER_CHKSUM_EN
    // 784 x 0x01 sums to 0x310, i.e. 0x10 mod 256.
    clr();
    send(8'h01);
    for (int i = 0; i < 784; i++) send(8'h01);
    send(8'h10);
    idle(4);
    chk("g_err_ok",  32'(bus.err),  0);
    chk("g_done_ok", 32'(done_cnt), 1);
    clr();
    send(8'h01);
    for (int i = 0; i < 784; i++) send(8'h01);
    send(8'h11);
    idle(4);
    chk("g_err_bad",  32'(bus.err),  1);
    chk("g_done_bad", 32'(done_cnt), 1);
    $display("checksum loads done");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nn_mem_loader.md
NN_MEM_LOADER -- requirements
Module: nn_mem_loader

Interface
REQ-001 Parameter N_IN, default 784, number of 8-bit input-vector entries per load.
REQ-002 Parameter N_W, default 784, number of 12-bit weight entries per load.
REQ-003 Parameter AW, default 16, memory address width.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 s_data  input  8  byte-stream payload.
REQ-007 s_valid  input  1  s_data is valid this cycle.
REQ-008 s_ready  output  1  loader accepts a byte this cycle; a transfer occurs when s_valid and s_ready are both 1.
REQ-009 in_we, in_addr, in_data  output  1/AW/8  input-vector memory write port.
REQ-010 w_we, w_addr, w_data  output  1/AW/12  weight memory write port.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse at load completion.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 States SHALL be IDLE, IN_LOAD, W_LO, W_HI and FIN.
REQ-015 IDLE: accepted byte 0x01 -> IN_LOAD; 0x02 -> W_LO; any other value -> stay in IDLE and set err.
REQ-016 Accepting a valid header (0x01/0x02) SHALL clear err and reset the entry counter to 0.
REQ-017 IN_LOAD: each accepted byte SHALL write in_data = byte at in_addr = counter, then increment the counter; after entry N_IN-1 -> FIN.
REQ-018 W_LO: accepted byte SHALL be held as weight bits [7:0] -> W_HI.
REQ-019 W_HI: accepted byte SHALL write w_data = {byte[3:0], held low byte} at w_addr = counter, then increment; after entry N_W-1 -> FIN, otherwise -> W_LO.
REQ-020 W_HI byte with byte[7:4] != 0 SHALL set err; the write still proceeds using byte[3:0].
REQ-021 Write strobes SHALL be registered: in_we/w_we high for exactly one cycle, the cycle after the accepting edge, with address and data valid in that same cycle.
REQ-022 s_ready SHALL be 1 in IDLE, IN_LOAD, W_LO and W_HI, and 0 in FIN.
REQ-023 FIN SHALL last one cycle, pulse done and return to IDLE.
REQ-024 s_valid low SHALL stall the FSM with no writes and no counter change; back-to-back bytes SHALL sustain one byte per cycle.
REQ-025 in_we and w_we SHALL never be high in the same cycle.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, and in_we=w_we=done=err=busy=0, addresses 0, data 0, s_ready=1 on the next cycle.
REQ-027 rst during a load SHALL abort it: no further writes, no done pulse, and no write for a byte presented in the reset cycle.

Configuration
REQ-028 Macro NN_LOADER_CHKSUM_EN defined: after the last payload byte, a CHK state SHALL accept one byte. The byte is compared to the mod-256 sum of all payload bytes, excluding the header. Mismatch sets err. Then -> FIN, with done pulsed regardless of the comparison.
REQ-029 Macro NN_LOADER_CHKSUM_EN undefined: there is no CHK state, and FIN follows the last payload byte directly.

Verification
REQ-030 rst 3 cycles, then header 0x01 and bytes 0x00..0xFF repeating for 784 bytes, s_valid held high -> 784 in_we pulses, in_addr 0..783, in_data[k]=k mod 256, done one cycle after the last write, busy low after.
REQ-031 Header 0x02 and byte pairs (0x34,0x0A) x784 -> 784 w_we pulses, w_data=0xA34, w_addr 0..783, err=0.
REQ-032 Weight high byte 0x5A -> w_data=0xA<low>, err=1 and held through done; the next 0x01 header clears err.
REQ-033 Header 0x07 -> err=1, state IDLE, no writes; s_valid toggled 1/0 during an 0x01 load -> writes occur only on accepted bytes.
REQ-034 rst asserted after 100 input bytes -> no writes after reset and no done; a fresh 0x01 load restarts at in_addr 0.
REQ-035 With NN_LOADER_CHKSUM_EN, an 0x01 load of 784 bytes of 0x01 plus checksum 0x10 -> err=0; checksum 0x11 -> err=1; done pulses in both cases.
